// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a show-ahead FIFO as header-plus-data bursts, flushing stale partial chunks on timeout.
module fifo_burst_reader #(
   parameter int WIDTH        = 32,
   parameter int FIFO_DEPTH   = 4,
   parameter int CHUNKSIZE    = 4,
   parameter int ADDR_WIDTH   = 32,
   parameter int WIN_BITS     = 10,
   parameter int FLUSH_CYCLES = 64
) (
   input  logic                           clk_in,
   input  logic                           reset_in,
   input  logic                           enable_in,
   input  logic [ADDR_WIDTH-1:0]          dstBase_in,
   input  logic [FIFO_DEPTH-1:0]          fDepth_in,
   input  logic [WIDTH-1:0]               fData_in,
   input  logic                           fValid_in,
   input  logic                           fValidChunk_in,
   output logic                           fReady_out,
   output logic                           bHdrValid_out,
   output logic [ADDR_WIDTH-1:0]          bAddr_out,
   output logic [$clog2(CHUNKSIZE):0]     bLen_out,
   input  logic                           bHdrReady_in,
   output logic [WIDTH-1:0]               bData_out,
   output logic                           bValid_out,
   output logic                           bLast_out,
   input  logic                           bReady_in,
   output logic                           busy_out
);
   localparam int LW = $clog2(CHUNKSIZE) + 1;
   localparam int TW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_MAX = TW'(FLUSH_CYCLES == 0 ? 0 : FLUSH_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
   state_t                state_q, state_d;
   logic [WIN_BITS-1:0]   offset_q, offset_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic [LW-1:0]         rem_q, rem_d, len_q, len_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  chunk_go, flush_go, beat;
   always_comb begin
      chunk_go = enable_in & fValidChunk_in;
      flush_go = (FLUSH_CYCLES != 0) && enable_in && fValid_in && !fValidChunk_in && timer_q == TIMER_MAX;
      beat     = (state_q == DATA) & fValid_in & bReady_in;
      state_d  = state_q;
      offset_d = offset_q;
      timer_d  = '0;
      rem_d    = rem_q;
      len_d    = len_q;
      addr_d   = addr_q;
      case (state_q)
         IDLE: begin
            if (enable_in && fValid_in && !fValidChunk_in && !flush_go) timer_d = timer_q + 1'b1;
            if (chunk_go || flush_go) begin
               state_d = HDR;
               len_d   = chunk_go ? LW'(CHUNKSIZE) : LW'(fDepth_in);
               addr_d  = dstBase_in + ADDR_WIDTH'(offset_q);
            end
         end
         HDR: if (bHdrReady_in) begin
            state_d = DATA;
            rem_d   = len_q;
         end
         DATA: if (beat) begin
            rem_d = rem_q - 1'b1;
            if (rem_q == LW'(1)) begin
               state_d  = IDLE;
               offset_d = offset_q + WIN_BITS'(len_q);
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state_q  <= IDLE;
         offset_q <= '0;
         timer_q  <= '0;
         rem_q    <= '0;
         len_q    <= '0;
         addr_q   <= '0;
      end else begin
         state_q  <= state_d;
         offset_q <= offset_d;
         timer_q  <= timer_d;
         rem_q    <= rem_d;
         len_q    <= len_d;
         addr_q   <= addr_d;
      end
   end
   assign busy_out      = state_q != IDLE;
   assign bHdrValid_out = state_q == HDR;
   assign bAddr_out     = addr_q;
   assign bLen_out      = len_q;
   assign bValid_out    = (state_q == DATA) & fValid_in;
   assign bData_out     = (state_q == DATA) ? fData_in : '0;
   assign fReady_out    = beat;
   assign bLast_out     = bValid_out & (rem_q == LW'(1));
endmodule
